// File: rtl/execute_cycle_pkg.sv
// Shared encodings for the execute stage: ALU operation codes, write-back
// select codes, forwarding select codes and branch-type bit positions.
// Decode, hazard and execute logic all import this one definition.
package execute_cycle_pkg;

  // ALU operation codes (ALUControl)
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLL  = 3'b111;

  // Write-back select codes (ResultSrc)
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Forwarding select codes (ForwardA/ForwardB); 11 falls back to the register value
  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_RESULTW = 2'b01;
  localparam logic [1:0] FWD_ALUM    = 2'b10;

  // One-hot branch-type bit positions
  localparam int BR_BEQ  = 0;
  localparam int BR_BNE  = 1;
  localparam int BR_BLT  = 2;
  localparam int BR_BGE  = 3;
  localparam int BR_BLTU = 4;
  localparam int BR_BGEU = 5;
  localparam int BR_W    = 6;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage.
// Ports:
//   A, B        operands
//   ALUControl  operation code (see execute_cycle_pkg ALU_*)
//   Result      operation result, modulo 2^XLEN
//   Zero        1 when Result is all zeros
module alu
  import execute_cycle_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;

  assign a_s = A;
  assign b_s = B;

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD:  Result = A + B;
      ALU_SUB:  Result = A - B;
      ALU_AND:  Result = A & B;
      ALU_OR:   Result = A | B;
      ALU_XOR:  Result = A ^ B;
      ALU_SLT:  Result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: Result = {{(XLEN-1){1'b0}}, (A < B)};
      // Only the low five bits of B are the shift amount
      ALU_SLL:  Result = A << B[4:0];
      default:  Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage of a 5-stage RV32 pipeline: operand forwarding, ALU,
// branch resolution, jump/branch target and the EX/MEM pipeline register.
// Ports:
//   clk, rst                 rising-edge clock, async active-low reset
//   RegWriteE..PCPlus4E      ID/EX control and data inputs
//   Branch[5:0]              one-hot branch type (beq,bne,blt,bge,bltu,bgeu)
//   ForwardAE/BE, ResultW    forwarding selects and write-back value
//   ZeroE, PCSrcE, PCTargetE combinational ALU-zero, redirect and target
//   *M                       registered EX/MEM outputs (1-cycle latency)
module execute_cycle
  import execute_cycle_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            ALUSrcE,
  input  logic            JumpE,
  input  logic [1:0]      ResultSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [5:0]      Branch,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RD_E,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            ZeroE,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M
);

  logic [XLEN-1:0]        src_a;
  logic [XLEN-1:0]        write_data;
  logic [XLEN-1:0]        src_b;
  logic [XLEN-1:0]        alu_result;
  logic signed [XLEN-1:0] src_a_s;
  logic signed [XLEN-1:0] write_data_s;
  logic [BR_W-1:0]        br_cond;

  logic            regwrite_q,  regwrite_d;
  logic            memwrite_q,  memwrite_d;
  logic [1:0]      resultsrc_q, resultsrc_d;
  logic [4:0]      rd_q,        rd_d;
  logic [XLEN-1:0] aluresult_q, aluresult_d;
  logic [XLEN-1:0] writedata_q, writedata_d;
  logic [XLEN-1:0] pcplus4_q,   pcplus4_d;

  // Forwarding muxes: the ALUResultM path uses the registered EX/MEM value,
  // so a dependent op issued right behind its producer needs no stall.
  always_comb begin
    case (ForwardAE)
      FWD_RESULTW: src_a = ResultW;
      FWD_ALUM:    src_a = aluresult_q;
      default:     src_a = RD1_E;
    endcase
  end

  always_comb begin
    case (ForwardBE)
      FWD_RESULTW: write_data = ResultW;
      FWD_ALUM:    write_data = aluresult_q;
      default:     write_data = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : write_data;

  alu #(.XLEN(XLEN)) u_alu (
    .A          (src_a),
    .B          (src_b),
    .ALUControl (ALUControlE),
    .Result     (alu_result),
    .Zero       (ZeroE)
  );

  // Branch comparator works on the forwarded register operands, never on
  // the immediate and independent of the ALU operation.
  assign src_a_s      = src_a;
  assign write_data_s = write_data;

  always_comb begin
    br_cond          = '0;
    br_cond[BR_BEQ]  = (src_a == write_data);
    br_cond[BR_BNE]  = (src_a != write_data);
    br_cond[BR_BLT]  = (src_a_s < write_data_s);
    br_cond[BR_BGE]  = (src_a_s >= write_data_s);
    br_cond[BR_BLTU] = (src_a < write_data);
    br_cond[BR_BGEU] = (src_a >= write_data);
  end

  // Multiple branch bits simply OR their conditions together
  assign PCSrcE    = JumpE | (|(Branch & br_cond));
  assign PCTargetE = PCE + Imm_Ext_E;

  always_comb begin
    regwrite_d  = RegWriteE;
    memwrite_d  = MemWriteE;
    resultsrc_d = ResultSrcE;
    rd_d        = RD_E;
    aluresult_d = alu_result;
    writedata_d = write_data;
    pcplus4_d   = PCPlus4E;
  end

  // EX/MEM register: no stall or flush; reset clears everything so an
  // in-flight instruction cannot enable a write after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      resultsrc_q <= 2'b00;
      rd_q        <= '0;
      aluresult_q <= '0;
      writedata_q <= '0;
      pcplus4_q   <= '0;
    end else begin
      regwrite_q  <= regwrite_d;
      memwrite_q  <= memwrite_d;
      resultsrc_q <= resultsrc_d;
      rd_q        <= rd_d;
      aluresult_q <= aluresult_d;
      writedata_q <= writedata_d;
      pcplus4_q   <= pcplus4_d;
    end
  end

  assign RegWriteM  = regwrite_q;
  assign MemWriteM  = memwrite_q;
  assign ResultSrcM = resultsrc_q;
  assign RD_M       = rd_q;
  assign ALUResultM = aluresult_q;
  assign WriteDataM = writedata_q;
  assign PCPlus4M   = pcplus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
module tb_execute_cycle;

  logic        clk, rst;
  logic        RegWriteE, MemWriteE, ALUSrcE, JumpE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [5:0]  Branch;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        ZeroE, PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  int checks   = 0;
  int failures = 0;

  // Model of the EX/MEM state
  logic        m_regw, m_memw;
  logic [1:0]  m_rsrc;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_wd, m_pc4;

  execute_cycle #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .JumpE(JumpE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .Branch(Branch),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RD_E(RD_E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .ZeroE(ZeroE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic longint to_signed(input logic [31:0] v);
    return v[31] ? (longint'(v) - 64'sd4294967296) : longint'(v);
  endfunction

  function automatic logic [31:0] mdl_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (to_signed(a) < to_signed(b)) ? 32'd1 : 32'd0;
      3'd6: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      default: return a << (b % 32);
    endcase
  endfunction

  function automatic logic [31:0] mdl_fwd(input logic [1:0] sel, input logic [31:0] regv,
                                          input logic [31:0] resw, input logic [31:0] alum);
    if (sel == 2'd1) return resw;
    if (sel == 2'd2) return alum;
    return regv;
  endfunction

  function automatic logic mdl_taken(input logic jump, input logic [5:0] br,
                                     input logic [31:0] a, input logic [31:0] b);
    logic t;
    t = jump;
    for (int k = 0; k < 6; k++) begin
      if (br[k]) begin
        case (k)
          0: t = t | (a == b);
          1: t = t | (a != b);
          2: t = t | (to_signed(a) < to_signed(b));
          3: t = t | (to_signed(a) >= to_signed(b));
          4: t = t | (longint'(a) < longint'(b));
          default: t = t | (longint'(a) >= longint'(b));
        endcase
      end
    end
    return t;
  endfunction

  function automatic logic [31:0] cur_srca();
    return mdl_fwd(ForwardAE, RD1_E, ResultW, m_alu);
  endfunction

  function automatic logic [31:0] cur_wd();
    return mdl_fwd(ForwardBE, RD2_E, ResultW, m_alu);
  endfunction

  function automatic logic [31:0] cur_res();
    return mdl_alu(ALUControlE, cur_srca(), ALUSrcE ? Imm_Ext_E : cur_wd());
  endfunction

  function automatic logic [104:0] m_vec();
    return {m_regw, m_memw, m_rsrc, m_rd, m_alu, m_wd, m_pc4};
  endfunction

  function automatic logic [104:0] dut_vec();
    return {RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M};
  endfunction

  task automatic model_reset();
    m_regw = 0; m_memw = 0; m_rsrc = 0; m_rd = 0; m_alu = 0; m_wd = 0; m_pc4 = 0;
  endtask

  // Compute next model state from the current E inputs, then advance the clock
  task automatic clock_step();
    logic [31:0] r, w;
    r = cur_res();
    w = cur_wd();
    @(posedge clk);
    #1;
    if (rst) begin
      m_regw = RegWriteE; m_memw = MemWriteE; m_rsrc = ResultSrcE; m_rd = RD_E;
      m_alu = r; m_wd = w; m_pc4 = PCPlus4E;
    end
  endtask

  task automatic drive_idle();
    RegWriteE = 0; MemWriteE = 0; ALUSrcE = 0; JumpE = 0; ResultSrcE = 0; ALUControlE = 0;
    Branch = 0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; RD_E = 0;
    ForwardAE = 0; ForwardBE = 0; ResultW = 0;
  endtask

  task automatic drive_random();
    RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); ALUSrcE = 1'($urandom);
    JumpE = ($urandom_range(0, 7) == 0); ResultSrcE = 2'($urandom);
    ALUControlE = 3'($urandom); Branch = 6'($urandom);
    RD1_E = $urandom; RD2_E = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
    Imm_Ext_E = $urandom; PCE = $urandom; PCPlus4E = $urandom; RD_E = 5'($urandom);
    ForwardAE = 2'($urandom); ForwardBE = 2'($urandom); ResultW = $urandom;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    rst = 0;
    RegWriteE = 1; MemWriteE = 1; RD1_E = 9; RD_E = 7; PCE = 32'h10; Imm_Ext_E = 32'h4;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== 105'd0) begin
      failures++; $display("FAIL reset_m_outputs got=%h want=0", dut_vec());
    end
    checks++;
    if (PCTargetE !== 32'h14) begin
      failures++; $display("FAIL reset_comb_target got=%h want=00000014", PCTargetE);
    end
    rst = 1;
    #1;
    checks++;
    if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0) begin
      failures++; $display("FAIL reset_release_write got=%b%b want=00", RegWriteM, MemWriteM);
    end
    drive_idle();
    clock_step();
  endtask

  task automatic test_add();
    drive_idle();
    RD1_E = 5; RD2_E = 7; ALUControlE = 3'b000; RegWriteE = 1; RD_E = 3;
    clock_step();
    checks++;
    if (ALUResultM !== 32'd12 || RD_M !== 5'd3 || RegWriteM !== 1'b1) begin
      failures++;
      $display("FAIL add_basic got alu=%h rd=%0d rw=%b want alu=0000000c rd=3 rw=1",
               ALUResultM, RD_M, RegWriteM);
    end
  endtask

  task automatic test_forwarding();
    ForwardAE = 2'b10; RD1_E = 32'hDEAD; RD2_E = 1; ALUControlE = 3'b001;
    clock_step();
    checks++;
    if (ALUResultM !== 32'd11) begin
      failures++; $display("FAIL fwd_alum got=%h want=0000000b", ALUResultM);
    end
    ForwardAE = 2'b00; RD1_E = 0; ForwardBE = 2'b01; ResultW = 4; RD2_E = 32'h55; ALUControlE = 3'b000;
    clock_step();
    checks++;
    if (ALUResultM !== 32'd4 || WriteDataM !== 32'd4) begin
      failures++; $display("FAIL fwd_resultw got alu=%h wd=%h want 4/4", ALUResultM, WriteDataM);
    end
    ForwardAE = 2'b11; RD1_E = 32'h30; ForwardBE = 2'b11; RD2_E = 32'h3; ResultW = 32'h999;
    #1;
    checks++;
    if (PCSrcE !== 1'b0 || ZeroE !== 1'b0) begin
      failures++; $display("FAIL fwd_code11_comb got z=%b p=%b want 0/0", ZeroE, PCSrcE);
    end
    clock_step();
    checks++;
    if (ALUResultM !== 32'h33 || WriteDataM !== 32'h3) begin
      failures++; $display("FAIL fwd_code11 got alu=%h wd=%h want 33/3", ALUResultM, WriteDataM);
    end
  endtask

  task automatic test_branch();
    drive_idle();
    RD1_E = 32'hFFFFFFFF; RD2_E = 1; Branch = 6'b000100;
    ALUSrcE = 1; Imm_Ext_E = 32'hFFFFFFF8; PCE = 32'h100;
    #1;
    checks++;
    if (PCSrcE !== 1'b1) begin
      failures++; $display("FAIL branch_blt got=%b want=1", PCSrcE);
    end
    checks++;
    if (PCTargetE !== 32'hF8) begin
      failures++; $display("FAIL branch_target got=%h want=000000f8", PCTargetE);
    end
    Branch = 6'b010000;
    #1;
    checks++;
    if (PCSrcE !== 1'b0) begin
      failures++; $display("FAIL branch_bltu got=%b want=0", PCSrcE);
    end
    Branch = 6'b010001;
    #1;
    checks++;
    if (PCSrcE !== 1'b0) begin
      failures++; $display("FAIL branch_multi_none got=%b want=0", PCSrcE);
    end
    Branch = 6'b010010;
    #1;
    checks++;
    if (PCSrcE !== 1'b1) begin
      failures++; $display("FAIL branch_multi_or got=%b want=1", PCSrcE);
    end
    clock_step();
  endtask

  task automatic test_jump();
    drive_idle();
    JumpE = 1; ResultSrcE = 2'b10; PCPlus4E = 32'h24; RegWriteE = 1; RD_E = 1;
    #1;
    checks++;
    if (PCSrcE !== 1'b1) begin
      failures++; $display("FAIL jump_pcsrc got=%b want=1", PCSrcE);
    end
    clock_step();
    checks++;
    if (PCPlus4M !== 32'h24 || ResultSrcM !== 2'b10) begin
      failures++; $display("FAIL jump_m got pc4=%h rs=%b want 00000024/10", PCPlus4M, ResultSrcM);
    end
  endtask

  task automatic test_alu_corners();
    drive_idle();
    RD1_E = 1; ALUSrcE = 1; Imm_Ext_E = 33; ALUControlE = 3'b111;
    clock_step();
    checks++;
    if (ALUResultM !== 32'd2) begin
      failures++; $display("FAIL sll_33 got=%h want=00000002", ALUResultM);
    end
    ALUSrcE = 0; RD1_E = 0; RD2_E = 1; ALUControlE = 3'b001;
    #1;
    checks++;
    if (ZeroE !== 1'b0) begin
      failures++; $display("FAIL sub_neg_zero got=%b want=0", ZeroE);
    end
    clock_step();
    checks++;
    if (ALUResultM !== 32'hFFFFFFFF) begin
      failures++; $display("FAIL sub_0_1 got=%h want=ffffffff", ALUResultM);
    end
    RD1_E = 5; RD2_E = 5;
    #1;
    checks++;
    if (ZeroE !== 1'b1) begin
      failures++; $display("FAIL sub_5_5_zero got=%b want=1", ZeroE);
    end
    RD1_E = 1; RD2_E = 32'hFFFFFFFF; ALUControlE = 3'b110;
    clock_step();
    checks++;
    if (ALUResultM !== 32'd1) begin
      failures++; $display("FAIL sltu_1_max got=%h want=00000001", ALUResultM);
    end
    ALUControlE = 3'b101;
    clock_step();
    checks++;
    if (ALUResultM !== 32'd0) begin
      failures++; $display("FAIL slt_1_neg1 got=%h want=00000000", ALUResultM);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 300; i++) begin
      drive_random();
      #1;
      r = cur_res();
      checks++;
      if ({ZeroE, PCSrcE, PCTargetE} !== {(r == 32'd0), mdl_taken(JumpE, Branch, cur_srca(), cur_wd()), PCE + Imm_Ext_E}) begin
        failures++;
        $display("FAIL rand_comb[%0d] got z=%b p=%b t=%h want z=%b p=%b t=%h", i, ZeroE, PCSrcE, PCTargetE,
                 (r == 32'd0), mdl_taken(JumpE, Branch, cur_srca(), cur_wd()), PCE + Imm_Ext_E);
      end
      clock_step();
      checks++;
      if (dut_vec() !== m_vec()) begin
        failures++; $display("FAIL rand_m[%0d] got=%h want=%h", i, dut_vec(), m_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    drive_idle();
    RD1_E = $urandom; RD2_E = $urandom; ALUControlE = 3'($urandom); RegWriteE = 1;
    clock_step();
    for (int i = 0; i < 40; i++) begin
      ForwardAE = 2'b10; ForwardBE = (i % 3 == 0) ? 2'b10 : 2'b00;
      RD1_E = $urandom; RD2_E = $urandom_range(0, 40); ALUControlE = 3'($urandom);
      ALUSrcE = 0;
      clock_step();
      checks++;
      if (ALUResultM !== m_alu || WriteDataM !== m_wd) begin
        failures++;
        $display("FAIL b2b[%0d] got alu=%h wd=%h want alu=%h wd=%h", i, ALUResultM, WriteDataM, m_alu, m_wd);
      end
    end
  endtask

  task automatic test_async_reset();
    drive_idle();
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'b01; RD_E = 5'd17;
    RD1_E = 32'h1234; RD2_E = 32'h1111; PCPlus4E = 32'h40; PCE = 32'h200; Imm_Ext_E = 32'h8;
    clock_step();
    checks++;
    if (dut_vec() !== m_vec()) begin
      failures++; $display("FAIL areset_load got=%h want=%h", dut_vec(), m_vec());
    end
    #2;
    rst = 0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 105'd0) begin
      failures++; $display("FAIL areset_immediate got=%h want=0", dut_vec());
    end
    checks++;
    if (PCTargetE !== 32'h208) begin
      failures++; $display("FAIL areset_comb_target got=%h want=00000208", PCTargetE);
    end
    @(posedge clk);
    #1;
    rst = 1;
    #1;
    checks++;
    if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0) begin
      failures++; $display("FAIL areset_no_write got=%b%b want=00", RegWriteM, MemWriteM);
    end
    RD_E = 5'd9; RD1_E = 32'h100;
    clock_step();
    checks++;
    if (dut_vec() !== m_vec()) begin
      failures++; $display("FAIL areset_first_capture got=%h want=%h", dut_vec(), m_vec());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forwarding();
    test_branch();
    test_jump();
    test_alu_corners();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, datapath width; only 32 is supported.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
REQ-003 The block SHALL have these ID/EX inputs:
- RegWriteE, MemWriteE, ALUSrcE, JumpE  in  1 each  control bits from the ID/EX register.
- ResultSrcE  in  2  write-back select: 00 ALU, 01 memory, 10 PC+4.
- ALUControlE  in  3  ALU operation.
- Branch  in  6  one-hot branch type: [0] beq, [1] bne, [2] blt, [3] bge, [4] bltu, [5] bgeu.
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  32 each  operands and PCs.
- RD_E  in  5  destination register.
REQ-004 The block SHALL have these forwarding inputs:
- ForwardAE, ForwardBE  in  2 each  00 register value, 01 ResultW, 10 ALUResultM.
- ResultW  in  32  write-back result.
REQ-005 The block SHALL have these outputs:
- ZeroE  out  1  ALU result equals zero.
- PCSrcE  out  1  redirect fetch.
- PCTargetE  out  32  redirect target.
- RegWriteM, MemWriteM  out  1 each  registered controls.
- ResultSrcM  out  2  registered controls.
- RD_M  out  5  registered destination register.
- ALUResultM, WriteDataM, PCPlus4M  out  32 each  registered EX/MEM data.

Function
REQ-006 SrcAE SHALL be RD1_E, ResultW or ALUResultM according to ForwardAE; code 11 SHALL select RD1_E.
REQ-007 The forwarded B value SHALL be chosen from RD2_E, ResultW or ALUResultM by ForwardBE in the same way, and this value SHALL be WriteDataE.
REQ-008 SrcBE SHALL be Imm_Ext_E when ALUSrcE=1, otherwise WriteDataE.
REQ-009 The ALU SHALL implement: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed, result 0/1), 110 SLTU (result 0/1), 111 SLL by SrcBE[4:0]; all arithmetic SHALL be modulo 2^32 with no overflow flag.
REQ-010 ZeroE SHALL be 1 exactly when the 32-bit ALU result is 0.
REQ-011 Branch conditions SHALL be evaluated on SrcAE versus the forwarded B value, independent of ALUControlE: eq, ne, signed lt/ge, unsigned lt/ge.
REQ-012 PCSrcE SHALL be combinational: JumpE OR (Branch bit k set AND condition k true).
REQ-013 If Branch has more than one bit set, PCSrcE SHALL be the OR of all selected conditions.
REQ-014 PCTargetE SHALL be PCE + Imm_Ext_E (JAL/branch target); JALR is outside this block's scope.
REQ-015 On each rising clk with rst=1, the EX/MEM register SHALL capture RegWriteE, MemWriteE, ResultSrcE, RD_E, the ALU result, WriteDataE and PCPlus4E.
REQ-016 The EX/MEM register SHALL have no stall and no flush input; flushing of a redirected instruction is the ID/EX register's responsibility.
REQ-017 Latency SHALL be 1 cycle from E inputs to M outputs.
REQ-018 The ALUResultM forwarding path SHALL use the registered ALUResultM, giving back-to-back dependent ALU operations a correct result without a stall.

Reset
REQ-019 While rst=0, all M outputs SHALL be 0 asynchronously: RegWriteM=0, MemWriteM=0, ResultSrcM=00, RD_M=0, ALUResultM=0, WriteDataM=0, PCPlus4M=0.
REQ-020 Reset asserted mid-operation SHALL discard the in-flight instruction, so no write is enabled on the first cycle after release.
REQ-021 The combinational outputs (ZeroE, PCSrcE, PCTargetE) SHALL follow their inputs during reset and are not reset-controlled.

Structure
REQ-022 A shared package SHALL hold the ALUControl codes, the ResultSrc codes, the Forward select codes and the Branch bit indices, so decode, hazard and execute use one definition.
REQ-023 The ALU SHALL be a sub-module named alu, with inputs A, B and ALUControl and outputs Result and Zero.
REQ-024 The forwarding muxes, branch comparator and EX/MEM register SHALL reside in execute_cycle.

Verification
REQ-025 Forward path: RD1_E=5, RD2_E=7, ALUSrcE=0, ALUControlE=000, no forwarding, RegWriteE=1, RD_E=3 -> after 1 clk ALUResultM=12, RD_M=3, RegWriteM=1.
REQ-026 Forwarding: with ALUResultM=12, apply ForwardAE=10, RD2_E=1, ALUControlE=001 -> next ALUResultM=11; with ForwardBE=01 and ResultW=4 -> SrcB equals 4.
REQ-027 Branch: Branch=000100 (blt), SrcA=FFFFFFFF, B=1 -> PCSrcE=1; Branch=010000 (bltu) with the same operands -> PCSrcE=0; PCE=0x100, Imm=0xFFFFFFF8 -> PCTargetE=0xF8.
REQ-028 Jump: JumpE=1, ResultSrcE=10, PCPlus4E=0x24 -> PCSrcE=1 and after clk PCPlus4M=0x24, ResultSrcM=10.
REQ-029 ALU corners: SLL with B=33 shifts by 1; SUB 0-1 -> FFFFFFFF and ZeroE=0; SUB 5-5 -> ZeroE=1; SLTU 1 vs FFFFFFFF -> 1.
REQ-030 Reset: hold nonzero M outputs, drive rst=0 mid-cycle -> all M outputs 0 immediately; on release, the first clk captures the current E inputs.
